// File: rtl/mem_bus_dma_pkg.sv
// mem_bus_dma_pkg: shared bus command codes and DMA state encodings.
`default_nettype none

package mem_bus_dma_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam int          DMA_STATE_W  = 5;
    localparam logic [4:0]  DMA_IDLE     = 5'b00001;
    localparam logic [4:0]  DMA_RD_ADDR  = 5'b00010;
    localparam logic [4:0]  DMA_RD_WAIT  = 5'b00100;
    localparam logic [4:0]  DMA_WR       = 5'b01000;
    localparam logic [4:0]  DMA_DONE     = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/dma_addr_ctr.sv
// dma_addr_ctr: address register with synchronous load and wrapping increment.
`default_nettype none

module dma_addr_ctr #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] val_i,
    input  logic          inc_i,
    output logic [AW-1:0] q_o
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Load wins over increment; the increment wraps modulo 2^AW.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_dma.sv
// mem_bus_dma: memory-bus initiator copying len 16-bit words from src to dst,
// three cycles per word (read address, read wait, write).
`default_nettype none

module mem_bus_dma
    import mem_bus_dma_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] r_data,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          done
);

    logic [DMA_STATE_W-1:0] state_q;
    logic [DMA_STATE_W-1:0] state_d;
    logic [AW-1:0]          rem_q;
    logic [AW-1:0]          rem_d;
    logic [DW-1:0]          data_q;
    logic [DW-1:0]          data_d;
    logic [AW-1:0]          cur_src;
    logic [AW-1:0]          cur_dst;
    logic                   accept;
    logic                   in_wr;

    assign accept = (state_q == DMA_IDLE) && start;
    assign in_wr  = (state_q == DMA_WR);

    dma_addr_ctr #(.AW(AW)) u_src_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (accept),
        .val_i  (src_addr),
        .inc_i  (in_wr),
        .q_o    (cur_src)
    );

    dma_addr_ctr #(.AW(AW)) u_dst_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (accept),
        .val_i  (dst_addr),
        .inc_i  (in_wr),
        .q_o    (cur_dst)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DMA_IDLE;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    // Read data is registered by the responder, so it is only valid in RD_WAIT.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = (len == '0) ? DMA_DONE : DMA_RD_ADDR;
                end
            end
            DMA_RD_ADDR: state_d = DMA_RD_WAIT;
            DMA_RD_WAIT: begin
                data_d  = r_data;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == AW'(1)) ? DMA_DONE : DMA_RD_ADDR;
            end
            DMA_DONE: state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    always_comb begin
        mem_cmd  = MNONE;
        mem_addr = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            DMA_IDLE: busy = 1'b0;
            DMA_RD_ADDR, DMA_RD_WAIT: begin
                mem_cmd  = MREAD;
                mem_addr = cur_src;
            end
            DMA_WR: begin
                mem_cmd  = MWRITE;
                mem_addr = cur_dst;
            end
            DMA_DONE: done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    assign w_data = data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_dma.sv
// tb_mem_bus_dma: RAM/LED/switch bus model with read/write scoreboards.
`default_nettype none

module tb_mem_bus_dma;
    import mem_bus_dma_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] r_data = '0;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          done;

    logic [15:0] ram [0:255];
    logic [15:0] led = '0;
    logic [7:0]  sw = '0;
    logic [1:0]  prev_cmd = MNONE;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_dma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .r_data   (r_data),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .w_data   (w_data),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bus_read(input logic [8:0] a);
        if (!a[8])
            return ram[a[7:0]];
        else if (a == 9'h140)
            return {8'h00, sw};
        else
            return 16'h0000;
    endfunction

    // Responders: registered read data, writes qualified by mem_cmd.
    always @(posedge clk) begin
        if (mem_cmd == MREAD)
            r_data <= bus_read(mem_addr);
        if (mem_cmd == MWRITE) begin
            if (!mem_addr[8])
                ram[mem_addr[7:0]] <= w_data;
            else if (mem_addr == 9'h100)
                led <= w_data;
        end
    end

    always @(negedge clk) begin
        if (mem_cmd == MREAD && prev_cmd != MREAD) begin
            if (exp_rd.size() != 0)
                check_eq("rd_addr", 32'(mem_addr), exp_rd.pop_front());
            else
                check_eq("rd_extra", 32'(mem_addr), 32'hFFFF_FFFF);
        end
        if (mem_cmd == MWRITE) begin
            if (exp_wr.size() != 0)
                check_eq("wr", {7'b0, mem_addr, w_data}, exp_wr.pop_front());
            else
                check_eq("wr_extra", {7'b0, mem_addr, w_data}, 32'hFFFF_FFFF);
        end
        prev_cmd <= mem_cmd;
    end

    task automatic push_expect(input logic [8:0] s, input logic [8:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [8:0] sa;
            logic [8:0] da;
            sa = s + 9'(i);
            da = d + 9'(i);
            exp_rd.push_back(32'(sa));
            exp_wr.push_back({7'b0, da, bus_read(sa)});
        end
    endtask

    task automatic run_xfer(input string tag, input logic [8:0] s, input logic [8:0] d,
                            input logic [8:0] l, input bit restart);
        int cyc;
        bit busy_ok;
        push_expect(s, d, int'(l));
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        busy_ok  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 2000) begin
            if (!busy) busy_ok = 1'b0;
            if (restart && cyc == 5) begin
                src_addr = 9'h000;
                dst_addr = 9'h0F0;
                len      = 9'd2;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(3 * int'(l) + 1));
        check_eq({tag, "_busy_during"}, {31'b0, busy_ok & busy}, 32'd1);
        // A start coincident with the done pulse must be dropped.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_done_after"}, {31'b0, done}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check_eq({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int n_done;
        logic [15:0] saved;

        for (int i = 0; i < 256; i++) ram[i] = 16'(i) ^ 16'h0F00;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd",   32'(mem_cmd),  32'(MNONE));
        check_eq("rst_addr",  32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(w_data),   32'd0);
        check_eq("rst_busy",  {31'b0, busy}, 32'd0);
        check_eq("rst_done",  {31'b0, done}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        ram[8'h10] = 16'hAAAA;
        ram[8'h11] = 16'h5555;
        ram[8'h12] = 16'h1234;
        run_xfer("copy", 9'h010, 9'h080, 9'd3, 1'b0);
        check_eq("copy_m0", 32'(ram[8'h80]), 32'h0000AAAA);
        check_eq("copy_m1", 32'(ram[8'h81]), 32'h00005555);
        check_eq("copy_m2", 32'(ram[8'h82]), 32'h00001234);

        saved = ram[8'h30];
        run_xfer("zero", 9'h020, 9'h030, 9'd0, 1'b0);
        check_eq("zero_ram", 32'(ram[8'h30]), 32'(saved));

        sw = 8'hA5;
        run_xfer("sw_led", 9'h140, 9'h100, 9'd1, 1'b0);
        check_eq("led", 32'(led), 32'h000000A5);

        ram[8'h00] = 16'h7777;
        run_xfer("wrap", 9'h1FE, 9'h020, 9'd3, 1'b0);
        check_eq("wrap_m0", 32'(ram[8'h20]), 32'h0);
        check_eq("wrap_m2", 32'(ram[8'h22]), 32'h00007777);

        saved = ram[8'hF0];
        run_xfer("busy_start", 9'h030, 9'h090, 9'd4, 1'b1);
        check_eq("busy_m3", 32'(ram[8'h93]), 32'(16'h0033 ^ 16'h0F00));
        check_eq("busy_untouched", 32'(ram[8'hF0]), 32'(saved));

        // Reset during the write of word 2: only word 1 may land.
        ram[8'hA1] = 16'hBEEF;
        exp_rd.push_back(32'h10);
        exp_rd.push_back(32'h11);
        exp_wr.push_back({7'b0, 9'h0A0, ram[8'h10]});
        src_addr = 9'h010;
        dst_addr = 9'h0A0;
        len      = 9'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("rst_mid_wr", 32'(mem_cmd), 32'(MWRITE));
        reset = 1'b0;
        #1;
        check_eq("rst_mid_cmd",  32'(mem_cmd), 32'(MNONE));
        check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("rst_mid_done", 32'(n_done), 32'd0);
        check_eq("rst_mid_w1", 32'(ram[8'hA0]), 32'h0000AAAA);
        check_eq("rst_mid_w2", 32'(ram[8'hA1]), 32'h0000BEEF);
        check_eq("rst_mid_rd_left", 32'(exp_rd.size()), 32'd0);
        check_eq("rst_mid_wr_left", 32'(exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_dma.md
Name: mem_bus_dma

Overview:
- Bus initiator on the CPU memory bus (mem_cmd / mem_addr / w_data / r_data).
- Copies a block of 16-bit words from a source address range to a destination range.
- Addresses use the same 9-bit map as the CPU: RAM at 0x000-0x0FF, LED port at 0x100, switch port at 0x140. This makes RAM→RAM copies, switch→RAM sampling and RAM→LED playback possible without the CPU.
- Sits beside the CPU. The top level muxes its outputs onto the bus whenever busy=1.

Parameters:
- AW, 9, address width; matches mem_addr.
- DW, 16, data width; matches r_data / w_data.

Ports:
- clk  in  1  rising-edge clock; same clock as CPU and RAM.
- reset  in  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  AW  first source address; captured on accepted start.
- dst_addr  in  AW  first destination address; captured on accepted start.
- len  in  AW  word count, 0..511; captured on accepted start.
- r_data  in  DW  read data returned by the addressed responder.
- mem_cmd  out  2  bus command: MNONE, MREAD or MWRITE.
- mem_addr  out  AW  bus address.
- w_data  out  DW  write data.
- busy  out  1  high from the accepted start until DONE is left.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset values: state=IDLE, mem_cmd=MNONE, mem_addr=0, w_data=0, busy=0, done=0, internal counters=0, data latch=0.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- States:
  - IDLE: on start=1, capture src, dst and len. If len=0, go to DONE; otherwise go to RD_ADDR.
  - RD_ADDR: mem_cmd=MREAD, mem_addr=cur_src. Go to RD_WAIT.
  - RD_WAIT: MREAD and address held. Latch r_data into the data register at the clock edge that leaves this state. Go to WR.
  - WR: mem_cmd=MWRITE, mem_addr=cur_dst, w_data=latched word. At the edge: cur_src+1, cur_dst+1, remaining-1. If remaining becomes 0, go to DONE; else go to RD_ADDR.
  - DONE: mem_cmd=MNONE, done=1 for exactly one cycle. Go to IDLE.
- Timing:
  - 3 cycles per word; total latency 3*len+1 cycles from the accepted start to the done pulse.
  - busy=1 in every state except IDLE.
- Rules:
  - The read address is held for two cycles because RAM read data is registered. Sampling r_data in RD_ADDR is forbidden.
  - Address arithmetic is modulo 2^AW: 0x1FF+1 wraps to 0x000, with no error flag.
  - Source and destination ranges may overlap. The copy is strictly ascending, word by word; no hazard protection.
  - start while busy=1 is ignored: no re-capture and no queuing.
  - start coincident with the done pulse is ignored. A new start is accepted from the next IDLE cycle onward.
  - reset asserted mid-transfer: bus returns to MNONE asynchronously, no done pulse, and the partial copy is left as is.
  - w_data holds its last value outside WR. Responders qualify it by mem_cmd only.

Decomposition:
- Shared defines file:
  - MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10, used by the CPU, DMA and all bus responders.
  - One-hot state encodings for DMA_IDLE, DMA_RD_ADDR, DMA_RD_WAIT, DMA_WR, DMA_DONE.
- One sub-module, dma_addr_ctr: AW-bit register with async active-low reset, synchronous load and increment. Instantiated twice, for cur_src and cur_dst.
- The remaining-count register and the FSM stay in the top module.

Test Plan:
- RAM copy: preload RAM[0x10..0x12]=0xAAAA,0x5555,0x1234; start src=0x010 dst=0x080 len=3.
  -> RAM[0x80..0x82] matches the source; done pulses exactly 10 cycles after start; busy high for cycles 1-10.
- Zero length: start len=0.
  -> no MREAD or MWRITE issued; done one cycle after start; RAM unchanged.
- Switch to LED: SW=0x0A5, start src=0x140 dst=0x100 len=1.
  -> LED register reads 0xA5; bus read phase returns 0x00A5.
- Wrap-around: start src=0x1FE dst=0x020 len=3.
  -> read addresses 0x1FE, 0x1FF, 0x000 in that order; writes to 0x020-0x022.
- Start while busy and reset mid-transfer:
  - Second start during a len=4 copy is ignored; only 4 writes occur.
  - reset=0 during the WR of word 2 -> mem_cmd=MNONE within the same cycle, busy=0, done never pulses, only word 1 is written.
